// File: rtl/jk_mode_counter.sv
// jk_mode_counter: J/K-mode modulo-MOD up/down counter with JK cell output.
// Define JK_CNT_SAT_EN to saturate at 0 and MOD-1 instead of wrapping.
module jk_mode_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  input  logic             k,
  output logic             q,
  output logic             qn,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc
);
  localparam logic ST_UP   = 1'b0;
  localparam logic ST_DOWN = 1'b1;
  localparam logic [WIDTH:0] L_MOD = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] L_TOP = (WIDTH+1)'(MOD - 1);
  logic             r_q;
  logic             r_state;
  logic             r_tc;
  logic [WIDTH-1:0] r_count;
  logic             w_up;
  logic             w_dn;
  logic             w_tg;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_up_cnt;
  logic [WIDTH-1:0] w_dn_cnt;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_q;
  logic             w_nxt_state;
  logic             w_nxt_tc;
  assign w_up = en & j & ~k;
  assign w_dn = en & ~j & k;
  assign w_tg = en & j & k;
  // Extra bit: MOD-1 is reached when +1 equals MOD, 0 when -1 borrows
  assign w_inc    = {1'b0, r_count} + (WIDTH+1)'(1);
  assign w_dec    = {1'b0, r_count} - (WIDTH+1)'(1);
  assign w_at_top = (w_inc == L_MOD);
  assign w_at_bot = w_dec[WIDTH];
`ifdef JK_CNT_SAT_EN
  assign w_up_cnt = w_at_top ? r_count : w_inc[WIDTH-1:0];
  assign w_dn_cnt = w_at_bot ? r_count : w_dec[WIDTH-1:0];
`else
  assign w_up_cnt = w_at_top ? '0 : w_inc[WIDTH-1:0];
  assign w_dn_cnt = w_at_bot ? L_TOP[WIDTH-1:0] : w_dec[WIDTH-1:0];
`endif
  assign w_nxt_count = w_up ? w_up_cnt : w_dn ? w_dn_cnt : w_tg ? '0 : r_count;
  assign w_nxt_q     = w_up ? 1'b1 : w_dn ? 1'b0 : w_tg ? ~r_q : r_q;
  assign w_nxt_state = w_up ? ST_UP : w_dn ? ST_DOWN : r_state;
  assign w_nxt_tc    = (w_up & w_at_top) | (w_dn & w_at_bot);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= 1'b0;
      r_state <= ST_UP;
      r_tc    <= 1'b0;
      r_count <= '0;
    end else begin
      r_q     <= w_nxt_q;
      r_state <= w_nxt_state;
      r_tc    <= w_nxt_tc;
      r_count <= w_nxt_count;
    end
  end
  assign q     = r_q;
  assign qn    = ~r_q;
  assign count = r_count;
  assign dir   = r_state;
  assign tc    = r_tc;
endmodule

// File: tb/tb_jk_mode_counter.sv
// tb_jk_mode_counter: directed and random stimulus against an integer reference model.
module tb_jk_mode_counter;
  localparam int WIDTH = 4;
  localparam int MOD   = 10;
`ifdef JK_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, en, j, k;
  logic q, qn, dir, tc;
  logic [WIDTH-1:0] count;
  int n_checks = 0;
  int n_errors = 0;
  int m_cnt, m_q, m_dir, m_tc;

  jk_mode_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .j(j), .k(k),
    .q(q), .qn(qn), .count(count), .dir(dir), .tc(tc)
  );

  always #30 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, int'(count), m_cnt);
    check({tag, ".q"}, int'(q), m_q);
    check({tag, ".qn"}, int'(qn), 1 - m_q);
    check({tag, ".dir"}, int'(dir), m_dir);
    check({tag, ".tc"}, int'(tc), m_tc);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_q = 0; m_dir = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit e, input bit jj, input bit kk);
    m_tc = 0;
    if (e) begin
      if (jj && !kk) begin
        m_q = 1; m_dir = 0;
        if (m_cnt == MOD - 1) begin m_tc = 1; m_cnt = SAT ? MOD - 1 : 0; end
        else m_cnt = m_cnt + 1;
      end else if (!jj && kk) begin
        m_q = 0; m_dir = 1;
        if (m_cnt == 0) begin m_tc = 1; m_cnt = SAT ? 0 : MOD - 1; end
        else m_cnt = m_cnt - 1;
      end else if (jj && kk) begin
        m_q = 1 - m_q; m_cnt = 0;
      end
    end
  endtask

  task automatic step(input string tag, input bit e, input bit jj, input bit kk);
    @(negedge clk);
    en = e; j = jj; k = kk;
    @(posedge clk);
    model_edge(e, jj, kk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; j = 1'b0; k = 1'b0;
    model_reset();
    #50;
    check_all("reset");
    #50 rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step("up", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("down", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("down_to5", 1'b1, 1'b0, 1'b1);
    check("at5", int'(count), 5);
    step("toggle1", 1'b1, 1'b1, 1'b1);
    step("toggle2", 1'b1, 1'b1, 1'b1);
    step("en0_a", 1'b0, 1'b1, 1'b0);
    step("en0_b", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("up_to7", 1'b1, 1'b1, 1'b0);
    check("at7", int'(count), 7);
    #19 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #5 rst = 1'b0;
    step("post_rst", 1'b1, 1'b1, 1'b0);
    check("post_rst_one", int'(count), 1);
    for (int i = 0; i < 8; i++) step("up_to9", 1'b1, 1'b1, 1'b0);
    #19 rst = 1'b1;
    #1 model_reset();
    check_all("rst_mid_tc_prep");
    #5 rst = 1'b0;
    for (int i = 0; i < 10; i++) step("wrap_then_rst", 1'b1, 1'b1, 1'b0);
    #19 rst = 1'b1;
    #1 model_reset();
    check_all("rst_mid_tc");
    #5 rst = 1'b0;
`ifdef JK_CNT_SAT_EN
    for (int i = 0; i < 8; i++) step("sat_prep", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("sat_up", 1'b1, 1'b1, 1'b0);
    step("sat_clr", 1'b1, 1'b1, 1'b1);
    step("sat_one", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("sat_down", 1'b1, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/jk_mode_counter.md
# jk_mode_counter

Synchronous modulo-MOD counter whose operating mode comes from a J/K control pair, with a companion single-bit JK cell output. It is the stage directly downstream of the J/K/clock stimulus generator in the Flip-Flop & Counter designs: it consumes `j`, `k` and `clk` and produces a count, direction flag and terminal-count pulse for display or cascading. All outputs are registered.

## Interface
- `WIDTH`, 4, count register width in bits.
- `MOD`, 10, count modulus; legal range 2 ≤ MOD ≤ 2^WIDTH.

- `clk`  in  1  system clock; rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  clock enable; 0 freezes all state.
- `j`  in  1  J control / count-up request.
- `k`  in  1  K control / count-down request.
- `q`  out  1  JK cell state.
- `qn`  out  1  always ~q.
- `count`  out  WIDTH  current count, always in 0..MOD-1.
- `dir`  out  1  last direction: 0 = up, 1 = down.
- `tc`  out  1  terminal-count pulse.

## Operation
- One clock domain (`clk`). Reset is asynchronous and active-high (`rst`).
- Reset values: `q`=0, `qn`=1, `count`=0, `dir`=0, `tc`=0.
- `en`=0 at an edge: `q`, `count` and `dir` hold; `tc` is forced to 0.
- `en`=1, mode decode at each rising edge:
  - 00, hold: `q`, `count` and `dir` hold; `tc`=0.
  - 10, up: `q`←1, `dir`←0, `count`←count+1. At MOD-1, `count` wraps to 0 and `tc`←1; otherwise `tc`←0.
  - 01, down: `q`←0, `dir`←1, `count`←count-1. At 0, `count` wraps to MOD-1 and `tc`←1; otherwise `tc`←0.
  - 11, toggle/clear: `q`←~q, `count`←0 synchronously, `dir` holds, `tc`←0.
- State machine: two states, UP (`dir`=0) and DOWN (`dir`=1). Mode 10 moves to UP and mode 01 moves to DOWN. Modes 00 and 11 and `en`=0 stay in the current state.
- Arithmetic is done at WIDTH+1 bits, then compared against MOD-1 or 0.
- `count` never takes a value ≥ MOD. When MOD = 2^WIDTH, wrap is the natural overflow.

## Timing
- Latency: every output reflects the inputs sampled at a rising edge, updated at that edge (1 cycle). There are no combinational input-to-output paths.
- `tc` is high for exactly the one cycle in which `count` shows the wrapped value (0 when counting up, MOD-1 when counting down).
- `j` and `k` are sampled only at the rising edge. Changes between edges have no effect.
- `rst` assertion clears all outputs immediately, with no clock edge needed, including mid-count and mid-`tc`-pulse.
- `rst` deassertion: the first active edge after release applies a normal mode decode from reset state.
- If `rst` and an edge coincide, reset wins.

## Configuration
- `JK_CNT_SAT_EN`, defined: saturating mode.
  - Up at MOD-1 holds `count` at MOD-1 with `tc`=1.
  - Down at 0 holds `count` at 0 with `tc`=1.
  - `tc` stays high for each consecutive cycle an up or down request is blocked at a limit.
  - `q` and `dir` still update normally.
- `JK_CNT_SAT_EN`, undefined: wrap-around behaviour as described in Operation.

## Test plan
Period 60 ns, WIDTH=4, MOD=10 unless stated otherwise.

1. `rst`=1 for 0–100 ns with j=k=0, then release and apply 3 edges → count=0, q=0, qn=1, dir=0, tc=0 throughout.
2. From count=0, j=1, k=0, 12 edges → count 1..9, 0, 1, 2. tc=1 only in the cycle count=0. q=1, dir=0.
3. From count=2, j=0, k=1, 4 edges → count 1, 0, 9, 8. tc=1 only while count=9. q=0, dir=1.
4. From count=5, q=0, dir=1, j=k=1, 2 edges → edge 1: count=0, q=1. Edge 2: count=0, q=0. dir stays 1 and tc stays 0. Then en=0 with j=1 for 2 edges → everything holds.
5. count=7 with j=1, assert `rst` 20 ns after an edge → all outputs reset within the same cycle, before the next edge. Release with j=1 → first edge gives count=1.
6. `JK_CNT_SAT_EN` defined.
   - From 8, j=1, 4 edges → count 9, 9, 9, 9; tc 0, 1, 1, 1.
   - From 1, k=1, 3 edges → count 0, 0, 0; tc 0, 1, 1.
